// File: rtl/trng_sample_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trng_sample_ctrl_pkg
//  Purpose  : Shared definitions for the TRNG collection sequencer: default
//             datapath widths and the sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package trng_sample_ctrl_pkg;

  localparam int unsigned C_CNT_W  = 32;
  localparam int unsigned C_WARM_W = 16;
  localparam int unsigned C_BITS_W = 9;
  localparam int unsigned C_TMO_W  = 16;

  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_CLR    = 3'd1;
  localparam logic [2:0] C_ST_WARM   = 3'd2;
  localparam logic [2:0] C_ST_SAMPLE = 3'd3;
  localparam logic [2:0] C_ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_CLR    = C_ST_CLR,
    ST_WARM   = C_ST_WARM,
    ST_SAMPLE = C_ST_SAMPLE,
    ST_DONE   = C_ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trng_ctrl_dncnt.sv
`default_nettype none
// ============================================================================
//  Module   : trng_ctrl_dncnt
//  Purpose  : Loadable down-counter with a zero flag. Stops at zero.
//  Ports    : clk, rst_n      clock / async active-low reset
//             load, load_val  synchronous load (has priority over dec)
//             dec             decrement enable
//             zero            count == 0
//  Revision : 1.0  initial release
// ============================================================================
module trng_ctrl_dncnt
  import trng_sample_ctrl_pkg::*;
#(
  parameter int unsigned W = C_TMO_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trng_sample_ctrl
//  Purpose  : Sequencer for one TRNG collection run: latch config, clear the
//             sample datapath, enable the ring oscillator, warm up, then count
//             sample strobes until the requested number is reached. Reports
//             completion (done) or a watchdog expiry (err_tmo).
//  Ports    : rng_clk, rst_n        clock / async active-low reset
//             start, abort          run request (IDLE only) / level abort
//             sample_cnt_cfg, warmup_cfg, bits_req, timeout_cfg  run config
//             cntr_balance_valid    sample strobe
//             sample_cnt1           latched sample period
//             rst_trng_logic        clear pulse for counter/collector
//             rosc_en, collect_en   oscillator / collector enables
//             busy, bit_cnt         run in progress / samples collected
//             done, err_tmo         completion / watchdog pulses
//  Revision : 1.0  initial release
// ============================================================================
module trng_sample_ctrl
  import trng_sample_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = C_CNT_W,
  parameter int unsigned WARM_W = C_WARM_W,
  parameter int unsigned BITS_W = C_BITS_W,
  parameter int unsigned TMO_W  = C_TMO_W
) (
  input  logic              rng_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  sample_cnt_cfg,
  input  logic [WARM_W-1:0] warmup_cfg,
  input  logic [BITS_W-1:0] bits_req,
  input  logic [TMO_W-1:0]  timeout_cfg,
  input  logic              cntr_balance_valid,
  output logic [CNT_W-1:0]  sample_cnt1,
  output logic              rst_trng_logic,
  output logic              rosc_en,
  output logic              collect_en,
  output logic              busy,
  output logic [BITS_W-1:0] bit_cnt,
  output logic              done,
  output logic              err_tmo
);

  state_t            r_state;
  state_t            w_next_state;

  logic [CNT_W-1:0]  r_scfg;
  logic [WARM_W-1:0] r_warm;
  logic [BITS_W-1:0] r_bits;
  logic [TMO_W-1:0]  r_tmo;
  logic [BITS_W-1:0] r_bit_cnt;

  logic              r_rst_logic;
  logic              r_rosc_en;
  logic              r_collect_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_start_acc;
  logic              w_valid_acc;
  logic              w_abort_evt;
  logic              w_timeout;
  logic              w_warm_load;
  logic              w_warm_dec;
  logic              w_warm_zero;
  logic              w_wd_load;
  logic              w_wd_dec;
  logic              w_wd_zero;
  logic [BITS_W-1:0] w_bit_cnt_inc;

  assign w_bit_cnt_inc = r_bit_cnt + BITS_W'(1);

  // Counters are loaded with (N-1) so that the zero flag is seen in the Nth
  // cycle of the phase, giving exactly N cycles of WARM / N idle SAMPLE
  // cycles before the watchdog fires.
  trng_ctrl_dncnt #(.W(WARM_W)) u_warm_cnt (
    .clk      (rng_clk),
    .rst_n    (rst_n),
    .load     (w_warm_load),
    .load_val (r_warm - WARM_W'(1)),
    .dec      (w_warm_dec),
    .zero     (w_warm_zero)
  );

  trng_ctrl_dncnt #(.W(TMO_W)) u_wdog_cnt (
    .clk      (rng_clk),
    .rst_n    (rst_n),
    .load     (w_wd_load),
    .load_val (r_tmo - TMO_W'(1)),
    .dec      (w_wd_dec),
    .zero     (w_wd_zero)
  );

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Priority inside each state: abort > valid > watchdog > start.
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_valid_acc  = 1'b0;
    w_abort_evt  = 1'b0;
    w_timeout    = 1'b0;
    w_warm_load  = 1'b0;
    w_warm_dec   = 1'b0;
    w_wd_load    = 1'b0;
    w_wd_dec     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_start_acc  = 1'b1;
          w_next_state = (bits_req == '0) ? ST_DONE : ST_CLR;
        end
      end

      ST_CLR: begin
        if (abort) begin
          w_abort_evt  = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_warm != '0) begin
          w_warm_load  = 1'b1;
          w_next_state = ST_WARM;
        end else begin
          w_wd_load    = 1'b1;
          w_next_state = ST_SAMPLE;
        end
      end

      ST_WARM: begin
        if (abort) begin
          w_abort_evt  = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_warm_zero) begin
          w_wd_load    = 1'b1;
          w_next_state = ST_SAMPLE;
        end else begin
          w_warm_dec   = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          w_abort_evt  = 1'b1;
          w_next_state = ST_IDLE;
        end else if (cntr_balance_valid) begin
          w_valid_acc = 1'b1;
          if (w_bit_cnt_inc == r_bits) begin
            w_next_state = ST_DONE;
          end else begin
            w_wd_load = 1'b1;
          end
        end else if (r_tmo != '0) begin
          if (w_wd_zero) begin
            w_timeout    = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_wd_dec = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_abort_evt  = abort;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Config latches, sample count and registered outputs. Outputs are decoded
  // from the next state so they line up with the state register.
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scfg       <= '0;
      r_warm       <= '0;
      r_bits       <= '0;
      r_tmo        <= '0;
      r_bit_cnt    <= '0;
      r_rst_logic  <= 1'b0;
      r_rosc_en    <= 1'b0;
      r_collect_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_scfg    <= sample_cnt_cfg;
        r_warm    <= warmup_cfg;
        r_bits    <= bits_req;
        r_tmo     <= timeout_cfg;
        r_bit_cnt <= '0;
      end else if (w_valid_acc && (r_bit_cnt != '1)) begin
        r_bit_cnt <= w_bit_cnt_inc;
      end

      r_rst_logic  <= (w_next_state == ST_CLR) || w_abort_evt || w_timeout;
      r_rosc_en    <= (w_next_state == ST_CLR) || (w_next_state == ST_WARM) ||
                      (w_next_state == ST_SAMPLE);
      r_collect_en <= (w_next_state == ST_SAMPLE);
      r_busy       <= (w_next_state != ST_IDLE);
      r_done       <= (w_next_state == ST_DONE);
      r_err        <= w_timeout;
    end
  end

  assign sample_cnt1    = r_scfg;
  assign rst_trng_logic = r_rst_logic;
  assign rosc_en        = r_rosc_en;
  assign collect_en     = r_collect_en;
  assign busy           = r_busy;
  assign bit_cnt        = r_bit_cnt;
  assign done           = r_done;
  assign err_tmo        = r_err;

endmodule
`default_nettype wire
